// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register: FSM state encodings and
// the width of the occupancy output.
package pipe_pkg;

    localparam int OCC_W = 2;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/reg_en_w.sv
// Enable register of parametrised width with asynchronous, active-high reset
// to a fixed value.
module reg_en_w #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Load on enable, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RESET_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end else begin
            data_q <= data_q;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional two-entry skid buffer that keeps s_ready free of any m_ready path.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               SKID      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [OCC_W-1:0] occ
);

    logic             main_en_s;
    logic [WIDTH-1:0] main_d_s;

    reg_en_w #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .en_i (main_en_s),
        .d_i  (main_d_s),
        .q_o  (m_data)
    );

    if (SKID == 1) begin : gen_skid

        logic [1:0]       state_q;
        logic [1:0]       state_d;
        logic             skid_en_s;
        logic             main_from_skid_s;
        logic             in_s;
        logic             out_s;
        logic [WIDTH-1:0] skid_q;

        reg_en_w #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_skid (
            .clk  (clk),
            .rst  (rst),
            .en_i (skid_en_s),
            .d_i  (s_data),
            .q_o  (skid_q)
        );

        assign in_s  = s_valid && s_ready;
        assign out_s = m_valid && m_ready;

        // Next-state and register-enable decode; flush overrides every transfer.
        always_comb begin
            state_d          = state_q;
            main_en_s        = 1'b0;
            skid_en_s        = 1'b0;
            main_from_skid_s = 1'b0;
            if (flush) begin
                state_d = ST_EMPTY;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (in_s) begin
                            main_en_s = 1'b1;
                            state_d   = ST_BUSY;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_BUSY: begin
                        if (in_s && !out_s) begin
                            skid_en_s = 1'b1;
                            state_d   = ST_FULL;
                        end else if (!in_s && out_s) begin
                            state_d = ST_EMPTY;
                        end else if (in_s && out_s) begin
                            main_en_s = 1'b1;
                            state_d   = ST_BUSY;
                        end else begin
                            state_d = ST_BUSY;
                        end
                    end
                    ST_FULL: begin
                        if (out_s) begin
                            main_en_s        = 1'b1;
                            main_from_skid_s = 1'b1;
                            state_d          = ST_BUSY;
                        end else begin
                            state_d = ST_FULL;
                        end
                    end
                    default: begin
                        state_d = ST_EMPTY;
                    end
                endcase
            end
        end

        assign main_d_s = main_from_skid_s ? skid_q : s_data;

        // State register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_EMPTY;
            end else begin
                state_q <= state_d;
            end
        end

        // Handshake outputs decode from the state flop only.
        always_comb begin
            s_ready = 1'b1;
            m_valid = 1'b0;
            occ     = 2'd0;
            case (state_q)
                ST_EMPTY: begin
                    s_ready = 1'b1;
                    m_valid = 1'b0;
                    occ     = 2'd0;
                end
                ST_BUSY: begin
                    s_ready = 1'b1;
                    m_valid = 1'b1;
                    occ     = 2'd1;
                end
                ST_FULL: begin
                    s_ready = 1'b0;
                    m_valid = 1'b1;
                    occ     = 2'd2;
                end
                default: begin
                    s_ready = 1'b1;
                    m_valid = 1'b0;
                    occ     = 2'd0;
                end
            endcase
        end

    end else begin : gen_noskid

        logic valid_q;
        logic valid_d;
        logic in_s;
        logic out_s;

        assign s_ready   = !valid_q || m_ready;
        assign in_s      = s_valid && s_ready;
        assign out_s     = valid_q && m_ready;
        assign main_en_s = in_s;
        assign main_d_s  = s_data;

        // Valid next-state: flush first, then a fresh beat, then a drain.
        always_comb begin
            valid_d = valid_q;
            if (flush) begin
                valid_d = 1'b0;
            end else if (in_s) begin
                valid_d = 1'b1;
            end else if (out_s) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
        end

        // Valid register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
            end
        end

        assign m_valid = valid_q;
        assign occ     = {1'b0, valid_q};

    end

endmodule
